// File: rtl/m_nto1_bus_mux_reg_pkg.sv
// ----------------------------------------------------------------------------
// m_nto1_bus_mux_reg_pkg
//   Shared definitions for the N-to-1 registered bus multiplexer.
//   - mux_mode_e : channel selection mode (fixed channel or round-robin)
// ----------------------------------------------------------------------------
package m_nto1_bus_mux_reg_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/m_nto1_bus_mux_reg_rr_arbiter.sv
// ----------------------------------------------------------------------------
// m_rr_arbiter
//   Round-robin arbiter: grants the first requesting channel at or after ptr,
//   wrapping from N_CH-1 back to 0.
//   Ports:
//     req    in   N_CH   per-channel request
//     ptr    in   CH_W   highest-priority channel this cycle (must be < N_CH)
//     enable in   1      when low, no grant is issued
//     grant  out  N_CH   one-hot grant (zero when no grant)
//     idx    out  CH_W   index of the granted channel (0 when no grant)
//     any    out  1      a grant was issued
// ----------------------------------------------------------------------------
module m_rr_arbiter
    import m_nto1_bus_mux_reg_pkg::*;
#(
    parameter int unsigned N_CH = 2,
    parameter int unsigned CH_W = 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            enable,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    // Two ordered scans: channels ptr..N_CH-1 first, then 0..ptr-1.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        if (enable) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!any && req[k] && (CH_W'(k) >= ptr)) begin
                    any      = 1'b1;
                    grant[k] = 1'b1;
                    idx      = CH_W'(k);
                end
            end
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!any && req[k] && (CH_W'(k) < ptr)) begin
                    any      = 1'b1;
                    grant[k] = 1'b1;
                    idx      = CH_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/m_nto1_bus_mux_reg.sv
// ----------------------------------------------------------------------------
// m_nto1_bus_mux_reg
//   N-to-1 bus multiplexer with registered output, valid/ready handshake,
//   fixed or round-robin channel selection and optional add of INC_VALUE.
//   Ports:
//     w_clock        in   1           rising-edge clock
//     w_reset        in   1           asynchronous active-high reset
//     w_bus_mux_in   in   N_CH*WIDTH  flattened inputs, channel k at [k*WIDTH +: WIDTH]
//     w_valid_in     in   N_CH        per-channel valid
//     w_ready_out    out  N_CH        per-channel grant, one-hot or zero (combinational)
//     w_channel      in   CH_W        channel selected in fixed mode
//     w_mode         in   1           0 = fixed, 1 = round-robin
//     w_increment    in   1           add INC_VALUE to the selected word
//     w_bus_mux_out  out  WIDTH       registered data
//     w_carry_out    out  1           registered carry of the add
//     w_channel_out  out  CH_W        registered source channel of w_bus_mux_out
//     w_valid_out    out  1           output register holds valid data
//     w_ready_in     in   1           consumer accepts data
// ----------------------------------------------------------------------------
module m_nto1_bus_mux_reg
    import m_nto1_bus_mux_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CH_W      = 1,
    parameter int unsigned INC_VALUE = 1
) (
    input  logic                   w_clock,
    input  logic                   w_reset,
    input  logic [N_CH*WIDTH-1:0]  w_bus_mux_in,
    input  logic [N_CH-1:0]        w_valid_in,
    output logic [N_CH-1:0]        w_ready_out,
    input  logic [CH_W-1:0]        w_channel,
    input  logic                   w_mode,
    input  logic                   w_increment,
    output logic [WIDTH-1:0]       w_bus_mux_out,
    output logic                   w_carry_out,
    output logic [CH_W-1:0]        w_channel_out,
    output logic                   w_valid_out,
    input  logic                   w_ready_in
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic             carry_q, carry_d;
    logic [CH_W-1:0]  chan_q,  chan_d;
    logic             valid_q, valid_d;
    logic [CH_W-1:0]  ptr_q,   ptr_d;

    logic             load;
    logic             grant_en;
    logic             rr_mode;
    logic             in_range;
    logic [N_CH-1:0]  fix_grant;
    logic [N_CH-1:0]  rr_grant;
    logic [CH_W-1:0]  rr_idx;
    logic             rr_any;
    logic [N_CH-1:0]  grant;
    logic             any_grant;
    logic [CH_W-1:0]  sel_idx;
    logic [WIDTH-1:0] sel;
    logic [WIDTH:0]   sum;

    m_rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arbiter (
        .req    (w_valid_in),
        .ptr    (ptr_q),
        .enable (grant_en && rr_mode),
        .grant  (rr_grant),
        .idx    (rr_idx),
        .any    (rr_any)
    );

    always_comb begin
        load     = !valid_q || w_ready_in;
        // Grants are suppressed while reset is asserted so ready_out reads 0.
        grant_en = load && !w_reset;
        rr_mode  = (w_mode == MODE_RR);
        in_range = (32'(w_channel) < N_CH);

        fix_grant = '0;
        if (grant_en && !rr_mode && in_range) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (CH_W'(k) == w_channel) begin
                    fix_grant[k] = w_valid_in[k];
                end
            end
        end

        grant     = rr_mode ? rr_grant : fix_grant;
        sel_idx   = rr_mode ? rr_idx : w_channel;
        any_grant = |grant;

        // AND-OR select keyed on the one-hot grant so X on ungranted
        // channels cannot reach the adder.
        sel = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            sel = sel | ({WIDTH{grant[k]}} & w_bus_mux_in[k*WIDTH +: WIDTH]);
        end

        sum = {1'b0, sel} + (w_increment ? {1'b0, WIDTH'(INC_VALUE)} : '0);

        data_d  = data_q;
        carry_d = carry_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = any_grant;
            if (any_grant) begin
                data_d  = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                chan_d  = sel_idx;
            end
        end

        ptr_d = ptr_q;
        if (rr_any) begin
            ptr_d = (32'(rr_idx) == N_CH - 1) ? '0 : rr_idx + 1'b1;
        end
    end

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign w_ready_out   = grant;
    assign w_bus_mux_out = data_q;
    assign w_carry_out   = carry_q;
    assign w_channel_out = chan_q;
    assign w_valid_out   = valid_q;

endmodule

// File: tb/tb_m_nto1_bus_mux_reg.sv
// ----------------------------------------------------------------------------
// tb_m_nto1_bus_mux_reg
//   Directed bench: a 4-channel instance for the main behaviour and a
//   3-channel instance for the out-of-range fixed-channel index.
// ----------------------------------------------------------------------------
module tb_m_nto1_bus_mux_reg;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        inc;
    logic        rdy_in;
    logic [1:0]  chan;

    logic [31:0] bus4;
    logic [3:0]  vld4;
    logic [3:0]  rdy4;
    logic [7:0]  out4;
    logic        cy4;
    logic [1:0]  ch4;
    logic        vo4;

    logic [23:0] bus3;
    logic [2:0]  vld3;
    logic [2:0]  rdy3;
    logic [7:0]  out3;
    logic        cy3;
    logic [1:0]  ch3;
    logic        vo3;

    int unsigned n_checks;
    int unsigned n_errors;

    m_nto1_bus_mux_reg #(
        .WIDTH     (8),
        .N_CH      (4),
        .CH_W      (2),
        .INC_VALUE (1)
    ) u_dut4 (
        .w_clock       (clk),
        .w_reset       (rst),
        .w_bus_mux_in  (bus4),
        .w_valid_in    (vld4),
        .w_ready_out   (rdy4),
        .w_channel     (chan),
        .w_mode        (mode),
        .w_increment   (inc),
        .w_bus_mux_out (out4),
        .w_carry_out   (cy4),
        .w_channel_out (ch4),
        .w_valid_out   (vo4),
        .w_ready_in    (rdy_in)
    );

    m_nto1_bus_mux_reg #(
        .WIDTH     (8),
        .N_CH      (3),
        .CH_W      (2),
        .INC_VALUE (1)
    ) u_dut3 (
        .w_clock       (clk),
        .w_reset       (rst),
        .w_bus_mux_in  (bus3),
        .w_valid_in    (vld3),
        .w_ready_out   (rdy3),
        .w_channel     (chan),
        .w_mode        (mode),
        .w_increment   (inc),
        .w_bus_mux_out (out3),
        .w_carry_out   (cy3),
        .w_channel_out (ch3),
        .w_valid_out   (vo3),
        .w_ready_in    (rdy_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        mode   = 1'b1;
        inc    = 1'b0;
        rdy_in = 1'b1;
        chan   = 2'd0;
        bus4   = '0;
        vld4   = 4'hF;
        bus3   = '0;
        vld3   = 3'b000;

        // Reset state, with all channels requesting.
        step();
        step();
        check("rst_ready_out", 32'(rdy4), 32'h0);
        check("rst_out",       32'(out4), 32'h0);
        check("rst_valid",     32'(vo4),  32'h0);
        check("rst_carry",     32'(cy4),  32'h0);
        check("rst_chan",      32'(ch4),  32'h0);
        rst  = 1'b0;
        vld4 = 4'h0;
        step();

        // Fixed mode, ch2 = 0x5A.
        mode = 1'b0;
        chan = 2'd2;
        bus4 = {8'h00, 8'h5A, 8'h00, 8'h00};
        vld4 = 4'b0100;
        #2;
        check("fix_ready_out", 32'(rdy4), 32'h4);
        step();
        check("fix_out",   32'(out4), 32'h5A);
        check("fix_chan",  32'(ch4),  32'h2);
        check("fix_valid", 32'(vo4),  32'h1);
        check("fix_carry", 32'(cy4),  32'h0);

        // Increment wrap and no-wrap on ch1.
        chan = 2'd1;
        inc  = 1'b1;
        bus4 = {8'h00, 8'h00, 8'hFF, 8'h00};
        vld4 = 4'b0010;
        #2;
        check("inc_ready_out", 32'(rdy4), 32'h2);
        step();
        check("inc_ff_out",   32'(out4), 32'h00);
        check("inc_ff_carry", 32'(cy4),  32'h1);
        check("inc_ff_chan",  32'(ch4),  32'h1);
        bus4 = {8'h00, 8'h00, 8'h7F, 8'h00};
        step();
        check("inc_7f_out",   32'(out4), 32'h80);
        check("inc_7f_carry", 32'(cy4),  32'h0);
        inc = 1'b0;

        // Fixed channel invalid while another channel is valid.
        chan = 2'd2;
        vld4 = 4'b0001;
        #2;
        check("fix_inv_ready_out", 32'(rdy4), 32'h0);
        step();
        check("fix_inv_valid", 32'(vo4), 32'h0);

        // Out-of-range index on the 3-channel instance.
        chan = 2'd3;
        vld3 = 3'b111;
        bus3 = {8'h33, 8'h22, 8'h11};
        vld4 = 4'b0000;
        #2;
        check("oor_ready_out", 32'(rdy3), 32'h0);
        step();
        check("oor_valid", 32'(vo3), 32'h0);
        vld3 = 3'b000;

        // Round-robin, all channels valid: 0,1,2,3,0,1,2,3.
        mode = 1'b1;
        chan = 2'd0;
        bus4 = {8'h13, 8'h12, 8'h11, 8'h10};
        vld4 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("rr_all_ready_out", 32'(rdy4), 32'h1 << (i % 4));
            step();
            check("rr_all_chan", 32'(ch4),  32'(i % 4));
            check("rr_all_out",  32'(out4), 32'h10 + 32'(i % 4));
            check("rr_all_valid", 32'(vo4), 32'h1);
        end

        // Round-robin with ch1 and ch3 only: 1,3,1,3.
        vld4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_odd_chan", 32'(ch4), (i % 2 == 0) ? 32'h1 : 32'h3);
        end

        // Backpressure: load ch0 (pointer is 0), then stall 3 cycles.
        vld4 = 4'hF;
        step();
        check("bp_load_out",  32'(out4), 32'h10);
        check("bp_load_chan", 32'(ch4),  32'h0);
        rdy_in = 1'b0;
        bus4   = {8'h93, 8'h92, 8'h77, 8'h90};
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_ready_out", 32'(rdy4), 32'h0);
            step();
            check("bp_hold_out",   32'(out4), 32'h10);
            check("bp_hold_chan",  32'(ch4),  32'h0);
            check("bp_hold_valid", 32'(vo4),  32'h1);
        end
        // Pointer frozen at 1 across the stall.
        rdy_in = 1'b1;
        #2;
        check("bp_ptr_ready_out", 32'(rdy4), 32'h2);
        step();
        check("bp_resume_out",  32'(out4), 32'h77);
        check("bp_resume_chan", 32'(ch4),  32'h1);
        // Only ch0 valid: wraps from pointer 2 to ch0, no bubble.
        vld4 = 4'b0001;
        bus4 = {8'h00, 8'h00, 8'h00, 8'h3C};
        #2;
        check("b2b_ready_out", 32'(rdy4), 32'h1);
        step();
        check("b2b_out",   32'(out4), 32'h3C);
        check("b2b_chan",  32'(ch4),  32'h0);
        check("b2b_valid", 32'(vo4),  32'h1);

        // Reset mid-stream with a valid word held: pointer is 1 here.
        vld4 = 4'hF;
        rst  = 1'b1;
        #1;
        check("async_rst_valid",     32'(vo4),  32'h0);
        check("async_rst_out",       32'(out4), 32'h0);
        check("async_rst_chan",      32'(ch4),  32'h0);
        check("async_rst_ready_out", 32'(rdy4), 32'h0);
        step();
        rst = 1'b0;
        #2;
        check("post_rst_ready_out", 32'(rdy4), 32'h1);
        step();
        check("post_rst_chan",  32'(ch4),  32'h0);
        check("post_rst_out",   32'(out4), 32'h3C);
        check("post_rst_valid", 32'(vo4),  32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
